// File: rtl/oled_spi_byte_tx.sv
// Byte-wide SPI mode-3 transmitter for the Pmod OLED: shifts one command/data
// byte out MSB-first, captures SDOUT, and pulses done when CS is released.
module oled_spi_byte_tx #(
    parameter int CLKS_PER_HALF = 4,
    parameter int GAP_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       dc_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       cs,
    output logic       dc
);

    localparam int HW = $clog2(CLKS_PER_HALF) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t        state;
    logic [HW-1:0] half_cnt;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    bit_cnt;
    logic          last_bit;
    logic [7:0]    tx_sr;
    logic [7:0]    rx_sr;

    assign last_bit = (bit_cnt == 3'd0);

    // NOTE: every register, including the shift registers, is cleared by the
    // async reset so an aborted byte can never leak into the next transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            half_cnt <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            sclk     <= 1'b1;
            mosi     <= 1'b0;
            cs       <= 1'b1;
            dc       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only; every output reads last
            // cycle's state, so the whole FSM updates atomically per edge.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr    <= data_in;
                        dc       <= dc_in;
                        cs       <= 1'b0;
                        mosi     <= data_in[7];
                        sclk     <= 1'b1;
                        busy     <= 1'b1;
                        half_cnt <= HALF_LAST;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (half_cnt == '0) begin
                        sclk     <= 1'b0;
                        bit_cnt  <= 3'd7;
                        half_cnt <= HALF_LAST;
                        state    <= SHIFT;
                    end else begin
                        half_cnt <= half_cnt - HW'(1);
                    end
                end
                SHIFT: begin
                    if (half_cnt != '0) begin
                        half_cnt <= half_cnt - HW'(1);
                    end else if (!sclk) begin
                        // rising SCLK edge: the slave's bit has been stable for the whole low phase
                        sclk     <= 1'b1;
                        rx_sr    <= {rx_sr[6:0], miso};
                        half_cnt <= HALF_LAST;
                    end else if (!last_bit) begin
                        sclk     <= 1'b0;
                        mosi     <= tx_sr[6];
                        tx_sr    <= {tx_sr[6:0], 1'b0};
                        bit_cnt  <= bit_cnt - 3'd1;
                        half_cnt <= HALF_LAST;
                    end else begin
                        cs       <= 1'b1;
                        done     <= 1'b1;
                        data_out <= rx_sr;
                        mosi     <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= GAP_LAST;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
